// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, CTRL/STATUS bit positions and FSM states for uart_apb_slave
package uart_apb_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    localparam int STATUS_TX_FULL  = 0;
    localparam int STATUS_RX_EMPTY = 1;
    localparam int STATUS_TIMEOUT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT_TX = 2'd2
    } state_t;

endpackage

// File: rtl/uart_apb_slave.sv
// rtl/uart_apb_slave.sv - APB3 register slave bridging DATA accesses to external UART TX/RX FIFOs
// Optional macro UART_APB_TIMEOUT_EN bounds the wait on a full TX FIFO.
module uart_apb_slave
    import uart_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [10:0] BAUD_RESET     = 11'd326
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  tx_fifo_dataIn,
    output logic        tx_fifo_writeEn,
    input  logic        tx_fifo_Full,
    input  logic [7:0]  rx_fifo_dataOut,
    output logic        rx_fifo_readEn,
    input  logic        rx_fifo_Empty,
    output logic [10:0] baud_final_value,
    output logic        irq
);

    state_t      state;
    logic [10:0] baud_q;
    logic [1:0]  ctrl_q;
    logic        sticky_q;
    logic [1:0]  reg_idx;
    logic        is_data;
    logic        timeout_hit;
    logic        unused_bits;

    assign reg_idx = paddr[3:2];
    assign is_data = (reg_idx == REG_DATA);
    assign unused_bits = ^{pwdata[31:11], paddr[1:0]};

`ifdef UART_APB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign timeout_hit = (state == ST_WAIT_TX) && (wait_cnt == TIMEOUT_CYCLES[7:0]);
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[7:0];
    assign timeout_hit = 1'b0;
`endif

    // Handshake and strobes are gated by reset so an abandoned WAIT_TX never pushes.
    always_comb begin
        pready          = 1'b0;
        pslverr         = 1'b0;
        tx_fifo_writeEn = 1'b0;
        rx_fifo_readEn  = 1'b0;
        if (!reset && psel && penable) begin
            case (state)
                ST_ACCESS: begin
                    if (is_data && pwrite) begin
                        if (!tx_fifo_Full) begin
                            pready          = 1'b1;
                            tx_fifo_writeEn = 1'b1;
                        end
                    end else if (is_data) begin
                        pready = 1'b1;
                        if (rx_fifo_Empty) pslverr = 1'b1;
                        else               rx_fifo_readEn = 1'b1;
                    end else begin
                        pready = 1'b1;
                    end
                end
                ST_WAIT_TX: begin
                    if (!tx_fifo_Full) begin
                        pready          = 1'b1;
                        tx_fifo_writeEn = 1'b1;
                    end else if (timeout_hit) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prdata = 32'd0;
        if (pready && !pwrite && state == ST_ACCESS) begin
            case (reg_idx)
                REG_DATA:   prdata = rx_fifo_Empty ? 32'd0 : {24'd0, rx_fifo_dataOut};
                REG_STATUS: prdata = {29'd0, sticky_q, rx_fifo_Empty, tx_fifo_Full};
                REG_BAUD:   prdata = {21'd0, baud_q};
                REG_CTRL:   prdata = {30'd0, ctrl_q};
                default:    prdata = 32'd0;
            endcase
        end
    end

    assign tx_fifo_dataIn   = tx_fifo_writeEn ? pwdata[7:0] : 8'd0;
    assign baud_final_value = baud_q;
    assign irq = (ctrl_q[CTRL_RX_IE] & ~rx_fifo_Empty) | (ctrl_q[CTRL_TX_IE] & ~tx_fifo_Full);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_q   <= BAUD_RESET;
            ctrl_q   <= 2'b00;
            sticky_q <= 1'b0;
`ifdef UART_APB_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (pready) begin
                        state <= ST_IDLE;
                        if (pwrite) begin
                            case (reg_idx)
                                REG_BAUD:   baud_q <= pwdata[10:0];
                                REG_CTRL:   ctrl_q <= pwdata[1:0];
                                REG_STATUS: if (pwdata[STATUS_TIMEOUT]) sticky_q <= 1'b0;
                                default: ;
                            endcase
                        end
                    end else if (penable && pwrite && is_data) begin
                        state <= ST_WAIT_TX;
`ifdef UART_APB_TIMEOUT_EN
                        wait_cnt <= 8'd0;
`endif
                    end
                end
                ST_WAIT_TX: begin
                    if (!psel || pready) begin
                        state <= ST_IDLE;
                        if (pslverr) sticky_q <= 1'b1;
                    end
`ifdef UART_APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_slave.sv
// tb/tb_uart_apb_slave.sv - directed self-checking bench for uart_apb_slave
module tb_uart_apb_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn;
    logic        tx_fifo_Full;
    logic [7:0]  rx_fifo_dataOut;
    logic        rx_fifo_readEn;
    logic        rx_fifo_Empty;
    logic [10:0] baud_final_value;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_apb_slave dut (
        .clk(clk), .reset(reset),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .tx_fifo_dataIn(tx_fifo_dataIn), .tx_fifo_writeEn(tx_fifo_writeEn), .tx_fifo_Full(tx_fifo_Full),
        .rx_fifo_dataOut(rx_fifo_dataOut), .rx_fifo_readEn(rx_fifo_readEn), .rx_fifo_Empty(rx_fifo_Empty),
        .baud_final_value(baud_final_value), .irq(irq)
    );

    // One APB transfer. full_cycles >= 0 holds tx_fifo_Full high for that many access-phase cycles.
    task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] wd, input int full_cycles,
                       output logic [31:0] rd, output logic err, output int waits,
                       output int pushes, output int pops, output logic [7:0] pushed, output bit hung);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; pushes = 0; pops = 0; pushed = 8'h00; hung = 1'b0; rd = 32'hx; err = 1'bx;
        forever begin
            if (full_cycles >= 0) tx_fifo_Full = (waits < full_cycles);
            @(negedge clk);
            pushes += int'(tx_fifo_writeEn);
            pops   += int'(rx_fifo_readEn);
            if (tx_fifo_writeEn) pushed = tx_fifo_dataIn;
            if (pready) begin
                rd = prdata; err = pslverr;
                break;
            end
            waits++;
            if (waits > 2000) begin hung = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        pushes += int'(tx_fifo_writeEn);
        pops   += int'(rx_fifo_readEn);
    endtask

    task automatic test_reset();
        reset = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'hFF;
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b0; rx_fifo_dataOut = 8'h99;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({pready, pslverr, tx_fifo_writeEn, rx_fifo_readEn} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000", {pready, pslverr, tx_fifo_writeEn, rx_fifo_readEn}); end
        n_cmp++; if (prdata !== 32'd0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        n_cmp++; if (baud_final_value !== 11'd326) begin n_fail++; $display("FAIL reset_baud_out: got %h expected 146", baud_final_value); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        #1; reset = 1'b0; psel = 1'b0; penable = 1'b0; rx_fifo_Empty = 1'b1;
    endtask

    task automatic test_regs();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        apb(1'b0, 4'h8, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h146) begin n_fail++; $display("FAIL read_baud: got %h expected 146", rd); end
        n_cmp++; if (err !== 1'b0 || w !== 0) begin n_fail++; $display("FAIL read_baud_err_wait: got err=%b waits=%0d expected 0/0", err, w); end
        apb(1'b1, 4'hC, 32'h3, -1, rd, err, w, pu, po, pd, hung);
        apb(1'b0, 4'hC, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL read_ctrl: got %h expected 3", rd); end
        apb(1'b1, 4'h9, 32'hFFFF_F123, -1, rd, err, w, pu, po, pd, hung);
        apb(1'b0, 4'hA, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h123) begin n_fail++; $display("FAIL baud_low_addr_bits: got %h expected 123", rd); end
        n_cmp++; if (baud_final_value !== 11'h123) begin n_fail++; $display("FAIL baud_out: got %h expected 123", baud_final_value); end
        apb(1'b1, 4'hC, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        tx_fifo_Full = 1'b1; rx_fifo_Empty = 1'b1;
        apb(1'b0, 4'h4, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h3) begin n_fail++; $display("FAIL status_full_empty: got %h expected 3", rd); end
        tx_fifo_Full = 1'b0;
    endtask

    task automatic test_tx_write();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        apb(1'b1, 4'h0, 32'h1234_56A5, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (pu !== 1 || pd !== 8'hA5) begin n_fail++; $display("FAIL tx_push: got %0d pushes data %h expected 1 pushes data a5", pu, pd); end
        n_cmp++; if (w !== 0 || err !== 1'b0) begin n_fail++; $display("FAIL tx_wait: got waits=%0d err=%b expected 0/0", w, err); end
    endtask

    task automatic test_rx_read();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        rx_fifo_Empty = 1'b0; rx_fifo_dataOut = 8'h3C;
        apb(1'b0, 4'h0, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h3C || err !== 1'b0) begin n_fail++; $display("FAIL rx_read: got %h err=%b expected 3c err=0", rd, err); end
        n_cmp++; if (po !== 1) begin n_fail++; $display("FAIL rx_pop_count: got %0d expected 1", po); end
        rx_fifo_Empty = 1'b1;
        apb(1'b0, 4'h0, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h0 || err !== 1'b1 || po !== 0) begin n_fail++;
            $display("FAIL rx_empty_read: got %h err=%b pops=%0d expected 0 err=1 pops=0", rd, err, po); end
    endtask

    task automatic test_tx_wait();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        apb(1'b1, 4'h0, 32'h11, 10, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (w !== 10 || hung) begin n_fail++; $display("FAIL tx_wait_cycles: got %0d expected 10", w); end
        n_cmp++; if (pu !== 1 || pd !== 8'h11 || err !== 1'b0) begin n_fail++;
            $display("FAIL tx_wait_push: got %0d pushes data %h err=%b expected 1/11/0", pu, pd, err); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
`ifdef UART_APB_TIMEOUT_EN
        apb(1'b1, 4'h0, 32'h22, 100000, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (hung || w !== 256 || err !== 1'b1 || pu !== 0) begin n_fail++;
            $display("FAIL timeout: got waits=%0d err=%b pushes=%0d expected 256/1/0", w, err, pu); end
        rx_fifo_Empty = 1'b0;
        apb(1'b0, 4'h4, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h5) begin n_fail++; $display("FAIL status_sticky: got %h expected 5", rd); end
        apb(1'b1, 4'h4, 32'h4, -1, rd, err, w, pu, po, pd, hung);
        apb(1'b0, 4'h4, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL status_w1c: got %h expected 1", rd); end
`else
        apb(1'b1, 4'h0, 32'h22, 300, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (hung || w !== 300 || err !== 1'b0 || pu !== 1) begin n_fail++;
            $display("FAIL long_wait: got waits=%0d err=%b pushes=%0d expected 300/0/1", w, err, pu); end
        rx_fifo_Empty = 1'b0;
        apb(1'b0, 4'h4, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL status_no_sticky: got %h expected 0", rd); end
`endif
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1;
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        tx_fifo_Full = 1'b1; rx_fifo_Empty = 1'b1;
        apb(1'b1, 4'hC, 32'h1, -1, rd, err, w, pu, po, pd, hung);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_idle: got %b expected 0", irq); end
        rx_fifo_Empty = 1'b0; #1;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx_set: got %b expected 1", irq); end
        rx_fifo_Empty = 1'b1;
        apb(1'b1, 4'hC, 32'h2, -1, rd, err, w, pu, po, pd, hung);
        tx_fifo_Full = 1'b0; #1;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_set: got %b expected 1", irq); end
        apb(1'b1, 4'hC, 32'h0, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        int strobes = 0;
        // psel dropped during the access phase
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h66; tx_fifo_Full = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b1;
        repeat (3) begin @(negedge clk); strobes += int'(tx_fifo_writeEn) + int'(pready); end
        tx_fifo_Full = 1'b0; penable = 1'b0;
        repeat (2) begin @(negedge clk); strobes += int'(tx_fifo_writeEn) + int'(pready); end
        n_cmp++; if (strobes !== 0) begin n_fail++; $display("FAIL psel_drop: got %0d strobes expected 0", strobes); end
        // reset while stalled in WAIT_TX
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwdata = 32'h77; tx_fifo_Full = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (4) @(posedge clk);
        #1; reset = 1'b1; tx_fifo_Full = 1'b0;
        @(negedge clk);
        strobes = int'(tx_fifo_writeEn) + int'(pready);
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (2) begin @(negedge clk); strobes += int'(tx_fifo_writeEn) + int'(pready); end
        n_cmp++; if (strobes !== 0) begin n_fail++; $display("FAIL reset_in_wait: got %0d strobes expected 0", strobes); end
        apb(1'b1, 4'h0, 32'h5A, -1, rd, err, w, pu, po, pd, hung);
        n_cmp++; if (pu !== 1 || pd !== 8'h5A || w !== 0) begin n_fail++;
            $display("FAIL after_reset_push: got %0d pushes data %h waits %0d expected 1/5a/0", pu, pd, w); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int w, pu, po; logic [7:0] pd; bit hung;
        int total = 0;
        logic [7:0] seen [2];
        for (int i = 0; i < 2; i++) begin
            apb(1'b1, 4'h0, 32'h01 + i, -1, rd, err, w, pu, po, pd, hung);
            total += pu; seen[i] = pd;
        end
        n_cmp++; if (total !== 2 || seen[0] !== 8'h01 || seen[1] !== 8'h02) begin n_fail++;
            $display("FAIL back_to_back: got %0d pushes data %h %h expected 2/01/02", total, seen[0], seen[1]); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_write();
        test_rx_read();
        test_tx_wait();
        test_timeout();
        test_irq();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
